// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: single write port into the VGA text buffer, shared by
// three round-robin requesters and a full-screen clear engine.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   clr_start  one-cycle request to fill the screen with CLEAR_DATA
//   req        per-requester write request (bit i = requester i)
//   req_addr   packed 12-bit cell addresses, requester i at [12i+11:12i]
//   req_data   packed 16-bit cell words, requester i at [16i+15:16i]
//   gnt        combinational one-hot grant (accepts addr/data this cycle)
//   clr_busy   high while the clear engine owns the port
//   drop_cnt   saturating count of granted writes with out-of-range address
//   vga_addr, vga_we, vga_data  registered text-buffer write port
module vga_write_arbiter #(
  parameter int          SCREEN_CELLS = 2400,
  parameter logic [15:0] CLEAR_DATA   = 16'h0e00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_start,
  input  logic [2:0]  req,
  input  logic [35:0] req_addr,
  input  logic [47:0] req_data,
  output logic [2:0]  gnt,
  output logic        clr_busy,
  output logic [7:0]  drop_cnt,
  output logic [11:0] vga_addr,
  output logic        vga_we,
  output logic [15:0] vga_data
);

  localparam int          NUM_REQ   = 3;
  localparam logic [12:0] CELLS     = 13'(SCREEN_CELLS);
  localparam logic [11:0] LAST_CELL = 12'(SCREEN_CELLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state, state_nxt;
  logic [11:0] cnt;
  logic [1:0]  rr_ptr;
  logic [1:0]  sel;
  logic        found;
  logic        grant_ok;
  logic        in_range;
  int          idx;

  logic [NUM_REQ-1:0][11:0] addr_arr;
  logic [NUM_REQ-1:0][15:0] data_arr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[12*i +: 12];
    assign data_arr[i] = req_data[16*i +: 16];
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = 2'(idx);
      end
    end
  end

  // clr_start wins over requests in IDLE; nothing is granted during CLEAR.
  assign grant_ok = rst && (state == IDLE) && !clr_start && found;
  assign in_range = ({1'b0, addr_arr[sel]} < CELLS);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start)         state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST_CELL)  state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (gated by reset so nothing leaks while rst is low)
  always_comb begin
    gnt      = grant_ok ? (3'b001 << sel) : 3'b000;
    clr_busy = rst && (state == CLEAR);
  end

  // Write port, clear counter, round-robin pointer and drop counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_we   <= 1'b0;
      vga_addr <= '0;
      vga_data <= '0;
      drop_cnt <= '0;
      rr_ptr   <= 2'd2;
      cnt      <= '0;
    end else begin
      vga_we <= 1'b0;
      if (state == CLEAR) begin
        vga_addr <= cnt;
        vga_data <= CLEAR_DATA;
        vga_we   <= 1'b1;
        // Park at 0 on the last cell instead of running past the screen.
        cnt      <= (cnt == LAST_CELL) ? 12'd0 : cnt + 12'd1;
      end else if (clr_start) begin
        cnt <= '0;
      end else if (grant_ok) begin
        rr_ptr <= sel;
        if (in_range) begin
          vga_addr <= addr_arr[sel];
          vga_data <= data_arr[sel];
          vga_we   <= 1'b1;
        end else if (drop_cnt != 8'hff) begin
          // Dropped write keeps the port's last address/data untouched.
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: reset state, round-robin fairness,
// single write, full clear with pending request and a stray clr_start,
// out-of-range drops with saturation, and reset in the middle of a clear.
module tb_vga_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_start;
  logic [2:0]  req;
  logic [11:0] a0, a1, a2;
  logic [15:0] d0, d1, d2;
  logic [2:0]  gnt;
  logic        clr_busy;
  logic [7:0]  drop_cnt;
  logic [11:0] vga_addr;
  logic        vga_we;
  logic [15:0] vga_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .req       (req),
    .req_addr  ({a2, a1, a0}),
    .req_data  ({d2, d1, d0}),
    .gnt       (gnt),
    .clr_busy  (clr_busy),
    .drop_cnt  (drop_cnt),
    .vga_addr  (vga_addr),
    .vga_we    (vga_we),
    .vga_data  (vga_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int bad_wr, bad_busy, bad_gnt, we_seen;
  logic [11:0] exp_addr [3];

  initial begin
    rst = 1'b0; clr_start = 1'b0; req = 3'b111;
    a0 = 12'd100; a1 = 12'd200; a2 = 12'd300;
    d0 = 16'h000a; d1 = 16'h000b; d2 = 16'h000c;
    exp_addr[0] = 12'd100; exp_addr[1] = 12'd200; exp_addr[2] = 12'd300;
    tick(); tick();

    // Reset state, with requests present to prove gnt is held off.
    chk("rst_gnt",   32'(gnt), 32'd0);
    chk("rst_busy",  32'(clr_busy), 32'd0);
    chk("rst_we",    32'(vga_we), 32'd0);
    chk("rst_addr",  32'(vga_addr), 32'd0);
    chk("rst_data",  32'(vga_data), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);

    // Fairness: all three requesting, requester 0 first after reset.
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(3'b001 << (i % 3)));
      tick();
      chk($sformatf("rr_we%0d", i),   32'(vga_we), 32'd1);
      chk($sformatf("rr_addr%0d", i), 32'(vga_addr), 32'(exp_addr[i % 3]));
    end
    req = 3'b000;

    // Single write from requester 0.
    a0 = 12'd810; d0 = 16'h0e01; req = 3'b001;
    #1;
    chk("single_gnt", 32'(gnt), 32'b001);
    tick();
    req = 3'b000;
    chk("single_we",   32'(vga_we), 32'd1);
    chk("single_addr", 32'(vga_addr), 32'd810);
    chk("single_data", 32'(vga_data), 32'h0e01);
    tick();
    chk("idle_we",   32'(vga_we), 32'd0);
    chk("idle_hold", 32'(vga_addr), 32'd810);

    // Clear with a pending request from requester 1; second clr_start at cnt=500.
    a1 = 12'd55; d1 = 16'h1234;
    clr_start = 1'b1; req = 3'b010;
    #1;
    chk("clr_n_gnt",  32'(gnt), 32'd0);
    chk("clr_n_busy", 32'(clr_busy), 32'd0);
    tick();
    clr_start = 1'b0;
    chk("clr_n1_busy", 32'(clr_busy), 32'd1);
    chk("clr_n1_we",   32'(vga_we), 32'd0);
    #1;
    chk("clr_n1_gnt",  32'(gnt), 32'd0);
    bad_wr = 0; bad_busy = 0; bad_gnt = 0;
    for (int k = 0; k < 2400; k++) begin
      tick();
      if (k == 500) clr_start = 1'b0;
      if (!(vga_we === 1'b1 && vga_addr === 12'(k) && vga_data === 16'h0e00)) bad_wr++;
      if (k < 2399 && clr_busy !== 1'b1) bad_busy++;
      if (k == 499) clr_start = 1'b1;
      #1;
      if (k < 2399 && gnt !== 3'b000) bad_gnt++;
    end
    chk("clr_writes", 32'(bad_wr), 32'd0);
    chk("clr_busy_span", 32'(bad_busy), 32'd0);
    chk("clr_gnt_held", 32'(bad_gnt), 32'd0);
    chk("clr_end_busy", 32'(clr_busy), 32'd0);
    chk("clr_end_gnt",  32'(gnt), 32'b010);
    tick();
    req = 3'b000;
    chk("post_clr_we",   32'(vga_we), 32'd1);
    chk("post_clr_addr", 32'(vga_addr), 32'd55);
    chk("post_clr_data", 32'(vga_data), 32'h1234);
    tick();
    chk("no_reclear_busy", 32'(clr_busy), 32'd0);
    chk("no_reclear_we",   32'(vga_we), 32'd0);

    // Out-of-range from requester 2: granted, dropped, counted.
    a2 = 12'd2400; d2 = 16'hbeef; req = 3'b100;
    #1;
    chk("oor_gnt", 32'(gnt), 32'b100);
    tick();
    chk("oor_we",   32'(vga_we), 32'd0);
    chk("oor_drop", 32'(drop_cnt), 32'd1);
    repeat (299) tick();
    req = 3'b000;
    chk("oor_sat", 32'(drop_cnt), 32'd255);
    // Last valid cell is written normally.
    a2 = 12'd2399; req = 3'b100;
    tick();
    req = 3'b000;
    chk("edge_we",   32'(vga_we), 32'd1);
    chk("edge_addr", 32'(vga_addr), 32'd2399);
    chk("edge_drop", 32'(drop_cnt), 32'd255);

    // Reset at counter 1000 aborts the clear for good.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (1000) tick();
    chk("mid_clr_addr", 32'(vga_addr), 32'd999);
    rst = 1'b0;
    tick();
    chk("abort_busy", 32'(clr_busy), 32'd0);
    chk("abort_we",   32'(vga_we), 32'd0);
    chk("abort_addr", 32'(vga_addr), 32'd0);
    chk("abort_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    we_seen = 0;
    repeat (10) begin
      tick();
      if (vga_we !== 1'b0 || clr_busy !== 1'b0) we_seen++;
    end
    chk("no_resume", 32'(we_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
